// File: rtl/rr_request_arbiter8_if.sv
// Request/grant bundle between eight requesters and rr_request_arbiter8.
// master: requester side (drives req/done); slave: arbiter side (drives grant).
interface rr_request_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_request_arbiter8.sv
// rr_request_arbiter8: 8-requester arbiter with registered one-hot grant,
// release on done / withdrawal / MAX_HOLD expiry and a forced idle cycle
// between grants so the downstream 8-to-3 encoder never sees two one-hot
// values back to back.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority (search
// starts after the last released index); leave undefined for fixed
// priority with bit 0 highest.
module rr_request_arbiter8 #(
  parameter int MAX_HOLD = 16,  // 0 disables the timeout
  parameter int CNT_W    = 8    // 2**CNT_W must exceed MAX_HOLD
) (
  input logic             clk,
  input logic             rst_n,
  rr_request_arbiter8_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       win_idx;
  logic             held_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] last_ptr_q, last_ptr_d;
  logic [2:0] g_idx;
  logic [2:0] scan_idx;
  logic       found;
`endif

  // The holder's own request line; used for the withdrawal check.
  assign held_req = |(bus.req & grant_q);

  // Winner selection among the currently asserted request lines.
  always_comb begin
    win_idx = 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
    found    = 1'b0;
    scan_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = last_ptr_q + 3'(k + 1);  // 3-bit add wraps 7 -> 0
      if (!found && bus.req[scan_idx]) begin
        win_idx = scan_idx;
        found   = 1'b1;
      end
    end
`else
    // Descending scan so the lowest set index is the last one written.
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[k]) win_idx = 3'(k);
    end
`endif
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Index of the current holder, recorded as last_ptr on release.
  always_comb begin
    g_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (grant_q[k]) g_idx = 3'(k);
    end
  end
`endif

  // State register: all arbiter state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 8'h00;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ptr_q <= 3'd7;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_ptr_q <= last_ptr_d;
`endif
    end
  end

  // Next-state logic: grant from IDLE, release from GRANT (done, then
  // withdrawal, then hold expiry); release always returns to IDLE, which
  // produces the mandatory empty cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_ptr_d = last_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (|bus.req) begin
          state_d = GRANT;
          grant_d = 8'b1 << win_idx;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (bus.done || !held_req || (HOLD_EN && hold_cnt_q == HOLD_LAST)) begin
          state_d   = IDLE;
          grant_d   = 8'h00;
          // Timeout only when expiry was the sole reason for release.
          timeout_d = !bus.done && held_req;
`ifdef ARB_ROUND_ROBIN_EN
          last_ptr_d = g_idx;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
      end
    endcase
  end

  // Outputs come straight from registers; grant_valid is derived from grant.
  always_comb begin
    bus.grant       = grant_q;
    bus.grant_valid = |grant_q;
    bus.timeout     = timeout_q;
  end

endmodule

// File: tb/tb_rr_request_arbiter8.sv
// Directed bench for rr_request_arbiter8 (MAX_HOLD = 4). Expected values
// follow the ARB_ROUND_ROBIN_EN build option when it is defined.
module tb_rr_request_arbiter8;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rr_request_arbiter8_if bus ();

  rr_request_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference 8-to-3 encoder for the downstream chain.
  function automatic logic [2:0] enc8(input logic [7:0] d);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 0; k < 8; k++) if (d[k]) c = 3'(k);
    return c;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output check against an expected grant and timeout.
  task automatic check_out(input string tag, input logic [7:0] exp_g, input logic exp_to);
    check_eq({tag, " grant"}, 32'(bus.grant), 32'(exp_g));
    check_eq({tag, " valid"}, 32'(bus.grant_valid), 32'(exp_g != 8'h00));
    check_eq({tag, " timeout"}, 32'(bus.timeout), 32'(exp_to));
    check_eq({tag, " onehot"}, 32'($countones(bus.grant) <= 1), 32'd1);
    $display("%s: grant=%02h valid=%0b timeout=%0b", tag, bus.grant, bus.grant_valid, bus.timeout);
  endtask

  logic [7:0] exp_g;
  logic [2:0] exp_code;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    repeat (2) step();
    check_out("reset", 8'h00, 1'b0);
    rst_n = 1'b1;

    // First grant, then asynchronous reset mid-grant.
    bus.req = 8'hFF;
    step();
    check_out("first grant", 8'h01, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async reset", 8'h00, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_out("grant after reset", 8'h01, 1'b0);

    // Walk the sequence with req=FF and done pulsed once per grant.
    for (int k = 1; k <= 9; k++) begin
      bus.done = 1'b1;
      step();
      check_out($sformatf("gap %0d", k), 8'h00, 1'b0);
      bus.done = 1'b0;
      step();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g    = 8'h01 << (k % 8);
      exp_code = 3'(k % 8);
`else
      exp_g    = 8'h01;
      exp_code = 3'd0;
`endif
      check_out($sformatf("seq %0d", k), exp_g, 1'b0);
      check_eq($sformatf("code %0d", k), 32'(enc8(bus.grant)), 32'(exp_code));
    end

    // Release, then go fully idle.
    bus.done = 1'b1;
    step();
    check_out("release", 8'h00, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    step();
    check_out("idle", 8'h00, 1'b0);

    // Sparse request: bit 5 wins in both builds.
    bus.req = 8'hA0;
    step();
    check_out("req A0", 8'h20, 1'b0);
    bus.req = 8'h00;
    step();
    check_out("withdraw", 8'h00, 1'b0);
    step();

    // Timeout: four grant cycles, one timeout/idle cycle, then regrant.
    bus.req = 8'h08;
    for (int k = 0; k < 4; k++) begin
      step();
      check_out($sformatf("hold %0d", k), 8'h08, 1'b0);
    end
    step();
    check_out("expire", 8'h00, 1'b1);
    step();
    check_out("regrant", 8'h08, 1'b0);
    bus.req = 8'h00;
    step();
    check_out("drop 08", 8'h00, 1'b0);

    // done in IDLE is ignored and does not block the grant.
    bus.done = 1'b1;
    step();
    check_out("done idle", 8'h00, 1'b0);
    bus.req = 8'h04;
    step();
    check_out("grant 04", 8'h04, 1'b0);

    // Withdrawal + done + new request together: one release, one gap.
    bus.req = 8'h20;
    step();
    check_out("simul release", 8'h00, 1'b0);
    bus.done = 1'b0;
    step();
    check_out("grant 20", 8'h20, 1'b0);
    check_eq("code 20", 32'(enc8(bus.grant)), 32'd5);
    bus.done = 1'b1;
    step();
    check_out("final release", 8'h00, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
